// File: rtl/imm_gen_stage.sv
// Registered RV immediate generator for the s2_decode stage: decodes the format from the
// opcode, extends the immediate to XLEN and presents it through a 2-entry skid buffer.
module imm_gen_stage #(
    parameter int XLEN    = 32,
    parameter bit EN_ZIMM = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_U    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    // The immediate is built 64 bits wide and truncated, so one set of rules serves both XLENs.
    function automatic entry_t decode(input logic [31:0] instr);
        entry_t     e;
        logic [63:0] imm_w;
        logic [2:0]  fmt;
        logic        ill;
        imm_w = 64'd0;
        fmt   = FMT_NONE;
        ill   = 1'b0;
        if (instr[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (instr[6:0])
                7'b0000011, 7'b0010011, 7'b1100111: fmt = FMT_I;
                7'b0011011: begin
                    if (XLEN == 64) begin
                        fmt = FMT_I;
                    end else begin
                        ill = 1'b1;
                    end
                end
                7'b0100011: fmt = FMT_S;
                7'b1100011: fmt = FMT_B;
                7'b1101111: fmt = FMT_J;
                7'b0110111, 7'b0010111: fmt = FMT_U;
                7'b1110011: begin
                    if (EN_ZIMM && instr[14]) begin
                        fmt = FMT_Z;
                    end else begin
                        fmt = FMT_I;
                    end
                end
                default: ill = 1'b1;
            endcase
        end
        case (fmt)
            FMT_I:   imm_w = {{52{instr[31]}}, instr[31:20]};
            FMT_S:   imm_w = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm_w = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J:   imm_w = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U:   imm_w = {{32{instr[31]}}, instr[31:12], 12'd0};
            FMT_Z:   imm_w = {59'd0, instr[19:15]};
            default: imm_w = 64'd0;
        endcase
        e.instr   = instr;
        e.imm     = imm_w[XLEN-1:0];
        e.fmt     = fmt;
        e.illegal = ill;
        return e;
    endfunction

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t dec_s;
    logic   accept_s;

    // Next-state for the output and skid slots; skid always drains before a new accept.
    always_comb begin
        dec_s        = decode(in_instr);
        accept_s     = in_valid && !skid_valid_q;
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_ready) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                skid_valid_d = 1'b1;
            end
        end else if (accept_s) begin
            if (!out_valid_q || out_ready) begin
                out_d       = dec_s;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = dec_s;
                skid_valid_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset clears valids and payloads alike.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready    = ~skid_valid_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_q.instr;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench: one XLEN=32 and one XLEN=64 instance share stimulus; expected
// results come from directed constants or an arithmetic reference model.
module tb_imm_gen_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_instr, a_out_imm;
    logic [2:0]  a_out_fmt;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [31:0] b_out_instr;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_fmt;

    imm_gen_stage #(.XLEN(32), .EN_ZIMM(1'b1)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_instr(a_out_instr), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
        .out_illegal(a_out_illegal));

    imm_gen_stage #(.XLEN(64), .EN_ZIMM(1'b1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_instr(b_out_instr), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
        .out_illegal(b_out_illegal));

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_cur;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] i32, input logic [2:0] f32,
                                input logic l32, input logic [63:0] i64, input logic [2:0] f64,
                                input logic l64);
        exp_t e;
        e.instr = ins; e.imm32 = i32; e.fmt32 = f32; e.ill32 = l32;
        e.imm64 = i64; e.fmt64 = f64; e.ill64 = l64;
        return e;
    endfunction

    // Reference: immediates as signed integers assembled from field weights.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t        e;
        longint      v;
        logic [63:0] vv;
        int          kind;
        bit          ill, rv64_only;
        v = 0; kind = 0; ill = 1'b0; rv64_only = 1'b0;
        if (ins[1:0] != 2'b11) ill = 1'b1;
        else begin
            case (ins[6:0])
                7'h03, 7'h13, 7'h67: kind = 1;
                7'h1B: begin kind = 1; rv64_only = 1'b1; end
                7'h23: kind = 2;
                7'h63: kind = 3;
                7'h6F: kind = 4;
                7'h37, 7'h17: kind = 5;
                7'h73: kind = ins[14] ? 6 : 1;
                default: ill = 1'b1;
            endcase
        end
        case (kind)
            1: begin v = longint'(ins[31:20]); if (ins[31]) v = v - 64'sd4096; end
            2: begin v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]); if (ins[31]) v = v - 64'sd4096; end
            3: begin
                v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (ins[31]) v = v - 64'sd4096;
            end
            4: begin
                v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (ins[31]) v = v - 64'sd1048576;
            end
            5: begin v = longint'(ins[31:12]) * 4096; if (ins[31]) v = v - 64'sd4294967296; end
            6: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        vv = v;
        e.instr = ins;
        e.imm64 = vv; e.fmt64 = 3'(kind); e.ill64 = ill;
        if (rv64_only) begin
            e.imm32 = 32'd0; e.fmt32 = 3'd0; e.ill32 = 1'b1;
        end else begin
            e.imm32 = vv[31:0]; e.fmt32 = 3'(kind); e.ill32 = ill;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 13);
        case (k)
            0: r[6:0] = 7'h03;   1: r[6:0] = 7'h13;   2: r[6:0] = 7'h67;
            3: r[6:0] = 7'h1B;   4: r[6:0] = 7'h23;   5: r[6:0] = 7'h63;
            6: r[6:0] = 7'h6F;   7: r[6:0] = 7'h37;   8: r[6:0] = 7'h17;
            9: r[6:0] = 7'h73;   10: r[6:0] = 7'h33;  11: r[6:0] = 7'h0F;
            12: r[1:0] = 2'($urandom_range(0, 2));
            default: r = r;
        endcase
        return r;
    endfunction

    // Input side: record the expectation for every accepted instruction.
    always @(negedge clk) begin
        if (!rst && !flush && in_valid && a_in_ready) sb_q.push_back(exp_cur);
    end

    // Output side: pop and compare whenever the DUT hands an entry downstream.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            chk("valid_agree", 64'(b_out_valid), 64'(a_out_valid));
            chk("ready_agree", 64'(b_in_ready), 64'(a_in_ready));
            if (a_out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_output actual=%h required=no_entry", a_out_instr);
                end else begin
                    e = sb_q.pop_front();
                    chk("instr32", 64'(a_out_instr), 64'(e.instr));
                    chk("imm32", 64'(a_out_imm), 64'(e.imm32));
                    chk("fmt32", 64'(a_out_fmt), 64'(e.fmt32));
                    chk("illegal32", 64'(a_out_illegal), 64'(e.ill32));
                    chk("instr64", 64'(b_out_instr), 64'(e.instr));
                    chk("imm64", b_out_imm, e.imm64);
                    chk("fmt64", 64'(b_out_fmt), 64'(e.fmt64));
                    chk("illegal64", 64'(b_out_illegal), 64'(e.ill64));
                end
            end
            if (flush) sb_q.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input exp_t e);
        bit ok;
        ok = 1'b0;
        in_instr = ins; exp_cur = e; in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (a_in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 64'(a_out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(a_in_ready), 64'd1);
        chk({tag, "_out_instr"}, 64'(a_out_instr), 64'd0);
        chk({tag, "_out_imm"}, 64'(a_out_imm), 64'd0);
        chk({tag, "_out_fmt"}, 64'(a_out_fmt), 64'd0);
        chk({tag, "_out_illegal"}, 64'(a_out_illegal), 64'd0);
        chk({tag, "_out_imm64"}, b_out_imm, 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = 32'd0;
        exp_cur = '0;
        @(negedge clk);
        check_reset_values("reset");
        step();
        rst = 1'b0;
        step();

        // Directed vectors with hand-computed results.
        send(32'hFFF00093, mk(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0));
        chk("latency_1cycle", 64'(a_out_valid), 64'd1);
        send(32'hFE112E23, mk(32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0));
        send(32'h001000EF, mk(32'h001000EF, 32'h00000800, 3'd4, 1'b0, 64'h0000000000000800, 3'd4, 1'b0));
        send(32'h800002B7, mk(32'h800002B7, 32'h80000000, 3'd5, 1'b0, 64'hFFFFFFFF80000000, 3'd5, 1'b0));
        send(32'h000FD073, mk(32'h000FD073, 32'h0000001F, 3'd6, 1'b0, 64'h000000000000001F, 3'd6, 1'b0));
        send(32'h00000010, mk(32'h00000010, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1));
        send(32'hFFF0809B, mk(32'hFFF0809B, 32'h00000000, 3'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0));
        step(); step();

        // Back-pressure: A held, B in skid, C stalled, then all three drain back-to-back.
        out_ready = 1'b0;
        send(32'h00500113, model(32'h00500113));
        send(32'h00C18263, model(32'h00C18263));
        chk("bp_in_ready_low", 64'(a_in_ready), 64'd0);
        chk("bp_out_instr_a", 64'(a_out_instr), 64'h00500113);
        in_instr = 32'h12345037; exp_cur = model(32'h12345037); in_valid = 1'b1;
        step(); step(); step();
        chk("bp_c_stalled", 64'(a_in_ready), 64'd0);
        chk("bp_hold_a", 64'(a_out_instr), 64'h00500113);
        out_ready = 1'b1;
        @(negedge clk);
        chk("nogap_a", 64'(a_out_valid), 64'd1);
        step();
        @(negedge clk);
        chk("nogap_b", 64'(a_out_valid), 64'd1);
        chk("bp_c_ready", 64'(a_in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("nogap_c", 64'(a_out_valid), 64'd1);
        step(); step();

        // Flush with two entries buffered: neither may ever appear.
        out_ready = 1'b0;
        send(32'h00100093, model(32'h00100093));
        send(32'h00200113, model(32'h00200113));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_out_valid", 64'(a_out_valid), 64'd0);
        chk("flush_in_ready", 64'(a_in_ready), 64'd1);
        out_ready = 1'b1;
        step(); step(); step();

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        send(32'h00300193, model(32'h00300193));
        send(32'h00400213, model(32'h00400213));
        in_instr = 32'h00500293; exp_cur = model(32'h00500293); in_valid = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();

        // Randomised traffic with random back-pressure and occasional flushes.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ins;
            ins       = rand_instr();
            in_instr  = ins;
            exp_cur   = model(ins);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        step();
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        chk("drain_out_valid", 64'(a_out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
